// File: rtl/polar_piso_if.sv
// Load and serial handshake bundle for the polar transmit serializer.
// The serializer takes the slave view; its producer and consumer take the master view.
interface polar_piso_if #(
  parameter int unsigned N = 200
);
  logic         load_valid;
  logic         load_ready;
  logic [N-1:0] parallel_in;
  logic         ser_valid;
  logic         ser_ready;
  logic         ser_out;
  logic         ser_first;
  logic         ser_last;
  logic         frame_done;

  modport master (
    output load_valid,
    output parallel_in,
    output ser_ready,
    input  load_ready,
    input  ser_valid,
    input  ser_out,
    input  ser_first,
    input  ser_last,
    input  frame_done
  );

  modport slave (
    input  load_valid,
    input  parallel_in,
    input  ser_ready,
    output load_ready,
    output ser_valid,
    output ser_out,
    output ser_first,
    output ser_last,
    output frame_done
  );
endinterface

// File: rtl/polar_piso.sv
// Parallel-in serial-out converter for polar codewords, LSB first, with a one-deep
// holding buffer so consecutive frames stream without an idle cycle.
module polar_piso #(
  parameter int unsigned N     = 200,
  parameter int unsigned CNT_W = 8
) (
  input logic        clk,
  input logic        reset,
  polar_piso_if.slave bus
);

  typedef enum logic {StIdle, StShift} state_e;

  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(N - 1);

  state_e           state;
  logic [N-1:0]     shreg;
  logic [N-1:0]     hold;
  logic             hold_full;
  logic [CNT_W-1:0] bit_cnt;
  logic             frame_done_q;

  logic ser_valid;
  logic ser_last;
  logic load;
  logic beat;
  logic last_beat;

  assign ser_valid = (state == StShift);
  assign ser_last  = ser_valid && (bit_cnt == LastIdx);
  assign load      = bus.load_valid && !hold_full;
  assign beat      = ser_valid && bus.ser_ready;
  assign last_beat = beat && ser_last;

  assign bus.load_ready = !hold_full;
  assign bus.ser_valid  = ser_valid;
  assign bus.ser_out    = ser_valid && shreg[0];
  assign bus.ser_first  = ser_valid && (bit_cnt == '0);
  assign bus.ser_last   = ser_last;
  assign bus.frame_done = frame_done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= StIdle;
      shreg        <= '0;
      hold         <= '0;
      hold_full    <= 1'b0;
      bit_cnt      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= last_beat;
      case (state)
        StIdle: begin
          if (load) begin
            shreg   <= bus.parallel_in;
            bit_cnt <= '0;
            state   <= StShift;
          end
        end
        StShift: begin
          if (last_beat) begin
            bit_cnt <= '0;
            // A held frame always wins; load_ready was low so no load can coincide.
            if (hold_full) begin
              shreg     <= hold;
              hold_full <= 1'b0;
            end else if (load) begin
              shreg <= bus.parallel_in;
            end else begin
              state <= StIdle;
            end
          end else begin
            if (beat) begin
              shreg   <= {1'b0, shreg[N-1:1]};
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (load) begin
              hold      <= bus.parallel_in;
              hold_full <= 1'b1;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_polar_piso.sv
// Bench for polar_piso: an N=8 instance for directed vectors and an N=200 instance for
// random streaming, both checked every cycle against a frame-queue model.
module tb_polar_piso;
  localparam int unsigned NS = 8;
  localparam int unsigned NL = 200;
  localparam int unsigned NW = 6;

  logic clk = 1'b0;
  logic reset;

  polar_piso_if #(.N(NS)) bs ();
  polar_piso_if #(.N(NL)) bl ();

  polar_piso #(.N(NS), .CNT_W(3)) dut_s (.clk(clk), .reset(reset), .bus(bs));
  polar_piso #(.N(NL), .CNT_W(8)) dut_l (.clk(clk), .reset(reset), .bus(bl));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: frames in flight per instance, index of the next bit of the head frame.
  logic [NL-1:0] fq [2][$];
  int            idx [2];
  logic          done_exp [2];
  logic          loaded [2];
  logic          blog [2][$];
  logic          flog [2][$];
  int            fd_cnt [2];
  logic          lr_low [2];

  function automatic void cmp1(string name, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endfunction

  function automatic void cmpi(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endfunction

  function automatic void step(int k, int n, logic lv, logic [NL-1:0] pin, logic sr, logic lr,
                               logic sv, logic so, logic sf, logic sl, logic fd);
    logic          e_sv, e_lr, e_so, e_sf, e_sl, beat, fin;
    logic [NL-1:0] cur;
    string         p;
    p = (k == 0) ? "s." : "l.";
    if (reset) begin
      fq[k].delete();
      idx[k]      = 0;
      done_exp[k] = 1'b0;
    end
    e_sv = fq[k].size() > 0;
    e_lr = fq[k].size() < 2;
    cur  = e_sv ? fq[k][0] : '0;
    e_so = e_sv && cur[idx[k]];
    e_sf = e_sv && idx[k] == 0;
    e_sl = e_sv && idx[k] == n - 1;
    cmp1({p, "load_ready"}, lr, e_lr);
    cmp1({p, "ser_valid"}, sv, e_sv);
    cmp1({p, "ser_out"}, so, e_so);
    cmp1({p, "ser_first"}, sf, e_sf);
    cmp1({p, "ser_last"}, sl, e_sl);
    cmp1({p, "frame_done"}, fd, done_exp[k]);
    if (fd === 1'b1) fd_cnt[k]++;
    if (lr !== 1'b1) lr_low[k] = 1'b1;
    loaded[k] = 1'b0;
    if (reset) return;
    beat = e_sv && sr;
    fin  = beat && idx[k] == n - 1;
    if (beat) begin
      blog[k].push_back(so);
      flog[k].push_back(sf);
    end
    done_exp[k] = fin;
    if (fin) begin
      cur    = fq[k].pop_front();
      idx[k] = 0;
    end else if (beat) begin
      idx[k]++;
    end
    if (lv && e_lr) begin
      fq[k].push_back(pin);
      loaded[k] = 1'b1;
    end
  endfunction

  task automatic cyc();
    @(negedge clk);
    step(0, NS, bs.load_valid, NL'(bs.parallel_in), bs.ser_ready, bs.load_ready, bs.ser_valid,
         bs.ser_out, bs.ser_first, bs.ser_last, bs.frame_done);
    step(1, NL, bl.load_valid, bl.parallel_in, bl.ser_ready, bl.load_ready, bl.ser_valid,
         bl.ser_out, bl.ser_first, bl.ser_last, bl.frame_done);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    for (int k = 0; k < 2; k++) begin
      blog[k].delete();
      flog[k].delete();
      fd_cnt[k] = 0;
      lr_low[k] = 1'b0;
    end
  endtask

  // Bit i of exp_bits is the value expected on accepted beat i.
  task automatic check_seq(string name, int k, logic [31:0] exp_bits, logic [31:0] exp_first,
                           int n, int n_fd);
    logic [31:0] ob, of;
    ob = '0;
    of = '0;
    for (int i = 0; i < blog[k].size() && i < 32; i++) begin
      ob[i] = blog[k][i];
      of[i] = flog[k][i];
    end
    cmpi({name, "_beats"}, blog[k].size(), n);
    cmpi({name, "_bits"}, ob, exp_bits);
    cmpi({name, "_first"}, of, exp_first);
    cmpi({name, "_done"}, fd_cnt[k], n_fd);
  endtask

  logic [NL-1:0] w [NW];
  logic          pat [4];
  int            sent;
  int            nerr;

  initial begin
    reset          = 1'b1;
    bs.load_valid  = 1'b0;
    bs.parallel_in = '0;
    bs.ser_ready   = 1'b0;
    bl.load_valid  = 1'b0;
    bl.parallel_in = '0;
    bl.ser_ready   = 1'b0;
    for (int k = 0; k < 2; k++) begin
      idx[k]      = 0;
      done_exp[k] = 1'b0;
      loaded[k]   = 1'b0;
    end
    clear_logs();
    repeat (3) cyc();
    cmp1("rst_load_ready", bs.load_ready, 1'b1);
    cmp1("rst_ser_valid", bs.ser_valid, 1'b0);
    cmp1("rst_ser_out", bs.ser_out, 1'b0);
    reset = 1'b0;
    bs.ser_ready = 1'b1;
    cyc();

    // A5 from idle, ready always high.
    clear_logs();
    bs.load_valid  = 1'b1;
    bs.parallel_in = 8'hA5;
    cyc();
    bs.load_valid = 1'b0;
    repeat (12) cyc();
    check_seq("t1", 0, 32'hA5, 32'h01, 8, 1);
    cmp1("t1_idle", bs.ser_valid, 1'b0);

    // F0 with ready toggling 1,0,0,1.
    clear_logs();
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    bs.load_valid  = 1'b1;
    bs.parallel_in = 8'hF0;
    for (int c = 0; c < 60 && blog[0].size() < 8; c++) begin
      bs.ser_ready = pat[c % 4];
      cyc();
      bs.load_valid = 1'b0;
    end
    bs.ser_ready = 1'b1;
    repeat (3) cyc();
    check_seq("t2", 0, 32'hF0, 32'h01, 8, 1);

    // 01 then 80 back to back: second frame waits in the hold buffer.
    clear_logs();
    bs.load_valid  = 1'b1;
    bs.parallel_in = 8'h01;
    cyc();
    bs.parallel_in = 8'h80;
    cyc();
    bs.load_valid = 1'b0;
    cmp1("t3_ready_low", bs.load_ready, 1'b0);
    repeat (20) cyc();
    check_seq("t3", 0, 32'h8001, 32'h0101, 16, 2);

    // 3C offered exactly on the last beat of 11 with hold empty.
    clear_logs();
    bs.load_valid  = 1'b1;
    bs.parallel_in = 8'h11;
    cyc();
    bs.load_valid = 1'b0;
    repeat (7) cyc();
    bs.load_valid  = 1'b1;
    bs.parallel_in = 8'h3C;
    cyc();
    bs.load_valid = 1'b0;
    repeat (12) cyc();
    check_seq("t4", 0, 32'h3C11, 32'h0101, 16, 2);
    cmp1("t4_ready_never_low", lr_low[0], 1'b0);

    // Two frames loaded, reset at beat 3 of the first.
    clear_logs();
    bs.load_valid  = 1'b1;
    bs.parallel_in = 8'hAA;
    cyc();
    bs.parallel_in = 8'h55;
    cyc();
    bs.load_valid = 1'b0;
    repeat (2) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cmp1("t5_valid_after_reset", bs.ser_valid, 1'b0);
    cmp1("t5_ready_after_reset", bs.load_ready, 1'b1);
    clear_logs();
    repeat (3) cyc();
    cmpi("t5_no_done", fd_cnt[0], 0);
    cmpi("t5_no_beats", blog[0].size(), 0);
    bs.load_valid  = 1'b1;
    bs.parallel_in = 8'hFF;
    cyc();
    bs.load_valid = 1'b0;
    repeat (12) cyc();
    check_seq("t5", 0, 32'hFF, 32'h01, 8, 1);

    // N=200 random streaming with random ready and gappy loads.
    clear_logs();
    for (int i = 0; i < NW; i++)
      for (int b = 0; b < NL; b++) w[i][b] = 1'($urandom_range(0, 1));
    sent = 0;
    for (int c = 0; c < 8000 && fd_cnt[1] < NW; c++) begin
      bl.ser_ready  = ($urandom_range(0, 3) != 0);
      bl.load_valid = (sent < NW) && ($urandom_range(0, 4) != 0);
      if (sent < NW) bl.parallel_in = w[sent];
      cyc();
      if (loaded[1]) sent++;
    end
    bl.load_valid = 1'b0;
    repeat (3) cyc();
    cmpi("t6_loaded", sent, NW);
    cmpi("t6_done", fd_cnt[1], NW);
    cmpi("t6_beats", blog[1].size(), NW * NL);
    nerr = 0;
    for (int i = 0; i < blog[1].size() && i < NW * NL; i++)
      if (blog[1][i] !== w[i / NL][i % NL]) nerr++;
    cmpi("t6_bits_wrong", nerr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/polar_piso.md
Name: polar_piso

Overview:
- Parallel-in serial-out converter on the transmit side of the polar datapath.
- Accepts a full N-bit polar codeword in one cycle and emits it one bit per accepted serial beat, bit 0 first. This order matches the receive-side deserializer, which fills index 0 first.
- Has a one-deep holding buffer, so the next codeword can be loaded while the current one shifts out. Back-to-back frames stream with no idle cycle between them.

Parameters:
- N, 200, codeword width in bits (N >= 2).
- CNT_W, 8, bit-counter width; must satisfy 2^CNT_W >= N.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- load_valid  input  1  parallel_in holds a codeword.
- load_ready  output  1  block can accept a codeword this cycle.
- parallel_in  input  N  codeword; bit 0 is transmitted first.
- ser_valid  output  1  ser_out carries a valid bit.
- ser_ready  input  1  downstream accepts the bit this cycle.
- ser_out  output  1  current serial bit.
- ser_first  output  1  current bit is bit 0 of a frame.
- ser_last  output  1  current bit is bit N-1 of a frame.
- frame_done  output  1  one-cycle pulse after the last bit of a frame is accepted.

Behaviour:
- **State elements:**
  - shreg[N-1:0]: active shift register.
  - bit_cnt[CNT_W-1:0].
  - state: IDLE or SHIFT.
  - hold[N-1:0] plus hold_full flag.
  - frame_done register.
- **Reset:**
  - state=IDLE; shreg, hold, bit_cnt = 0; hold_full=0; frame_done=0.
  - Outputs at reset: load_ready=1, ser_valid=0, ser_out=0, ser_first=0, ser_last=0.
  - Reset mid-frame discards both the active and held frames; no frame_done is produced for them.
- **Combinational outputs:**
  - load_ready = !hold_full.
  - ser_valid = (state==SHIFT).
  - ser_out = ser_valid ? shreg[0] : 0.
  - ser_first = ser_valid && bit_cnt==0.
  - ser_last = ser_valid && bit_cnt==N-1.
- **Events:**
  - load = load_valid && load_ready.
  - beat = ser_valid && ser_ready.
  - end = beat && ser_last.
- **IDLE:**
  - On load: shreg<=parallel_in, bit_cnt<=0, state<=SHIFT.
  - The first bit is valid on the cycle after load (load-to-first-bit latency = 1).
- **SHIFT, beat && !end:** shreg<=shreg>>1 with MSB filled with 0; bit_cnt<=bit_cnt+1.
- **SHIFT, !beat:** all state holds. ser_out, ser_first and ser_last stay stable while ser_valid=1 and ser_ready=0.
- **SHIFT, end, with hold_full:**
  - shreg<=hold, hold_full<=0, bit_cnt<=0, state stays SHIFT.
  - The next frame's bit 0 is valid the very next cycle (zero bubble).
  - load_ready was 0 this cycle, so no load can coincide.
- **SHIFT, end, without hold_full:**
  - If load: shreg<=parallel_in, bit_cnt<=0, stay SHIFT (zero bubble).
  - Else: state<=IDLE.
- **SHIFT, load && !end:** hold<=parallel_in, hold_full<=1.
- **frame_done:** <= end, registered; high for exactly one cycle after each completed frame.
- **Capacity:** at most 2 codewords in flight (active + hold). load_ready deasserts exactly while hold_full=1.
- **Control independence:** ser_ready has no effect in IDLE, and load_valid is ignored while load_ready=0.

Test Plan:
- N=8: load 8'hA5 in IDLE with ser_ready=1 -> from the next cycle ser_out = 1,0,1,0,0,1,0,1 on 8 consecutive cycles; ser_first on beat 0, ser_last on beat 7; frame_done pulses once, on the cycle after beat 7; then ser_valid=0.
- N=8, load 8'hF0, toggle ser_ready 1,0,0,1,... -> every bit is held stable while ready is low; sequence is 0,0,0,0,1,1,1,1; exactly 8 beats; bit_cnt never skips.
- N=8, load 8'h01 then 8'h80 on the next cycle -> load_ready=0 after the second load until the first frame's end; output is 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1 with no gap; ser_first on beats 0 and 8.
- N=8, frame active with hold empty, load 8'h3C on the exact cycle of the last beat -> the new frame starts the next cycle; hold_full stays 0; load_ready stays 1.
- N=8, load two frames, assert reset at beat 3 for 1 cycle -> ser_valid=0, load_ready=1, no frame_done; a new load of 8'hFF then produces 8 ones cleanly.
- Default N=200, streaming random codewords with random ser_ready -> scoreboard matches LSB-first order; frame_done count equals the number of loaded codewords.
